// File: rtl/mbscore_int_arbiter_if.sv
// Bus bundle between the interrupt arbiter and its environment: raw requests,
// mask programming, the int_vec handshake towards the interrupt controller and
// the end-of-interrupt / in-service tracking back from the core.
interface mbscore_int_arbiter_if #(
  parameter int NUM_SRC   = 7,
  parameter int VEC_WIDTH = 3
);
  logic                 syscall_req;
  logic [NUM_SRC-2:0]   irq_in;
  logic                 mask_we;
  logic [NUM_SRC-1:0]   mask_wdata;
  logic                 int_ack;
  logic                 eoi;
  logic [VEC_WIDTH-1:0] int_vec;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   mask;
  logic [VEC_WIDTH-1:0] in_service;

  // Environment side: core, peripherals and downstream controller
  modport master (
    output syscall_req, irq_in, mask_we, mask_wdata, int_ack, eoi,
    input  int_vec, pending, mask, in_service
  );

  // Arbiter side
  modport slave (
    input  syscall_req, irq_in, mask_we, mask_wdata, int_ack, eoi,
    output int_vec, pending, mask, in_service
  );
endinterface

// File: rtl/mbscore_int_arbiter.sv
// Upstream stage of the core interrupt controller. Peripheral lines are
// synchronised and edge-detected, syscall is taken directly; requests latch as
// pending, the lowest unmasked index wins, and the chosen code is held on
// int_vec until acknowledged. The acknowledged code is then tracked as
// in_service until end-of-interrupt; no nesting is allowed.
module mbscore_int_arbiter #(
  parameter int NUM_SRC   = 7,
  parameter int VEC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mbscore_int_arbiter_if.slave bus
);

  localparam int NUM_PERIPH = NUM_SRC - 1;

  localparam logic [NUM_SRC-1:0]    SRC_NONE    = {NUM_SRC{1'b0}};
  localparam logic [NUM_SRC-1:0]    SRC_ALL     = {NUM_SRC{1'b1}};
  localparam logic [NUM_PERIPH-1:0] PERIPH_NONE = {NUM_PERIPH{1'b0}};
  localparam logic [VEC_WIDTH-1:0]  VEC_NONE    = {VEC_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Code of the lowest-index set bit (index + 1), or 0 when nothing is set.
  // Scanning from the top down lets the lowest index overwrite last.
  function automatic logic [VEC_WIDTH-1:0] prio_code(input logic [NUM_SRC-1:0] elig);
    logic [VEC_WIDTH-1:0] code;
    code = VEC_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      code = elig[i] ? VEC_WIDTH'(i + 1) : code;
    end
    return code;
  endfunction

  // One-hot source mask for an int_vec code; code 0 decodes to no source.
  function automatic logic [NUM_SRC-1:0] code_onehot(input logic [VEC_WIDTH-1:0] code);
    logic [NUM_SRC-1:0] oh;
    oh = SRC_NONE;
    for (int i = 0; i < NUM_SRC; i++) begin
      oh[i] = (code == VEC_WIDTH'(i + 1));
    end
    return oh;
  endfunction

  logic [NUM_PERIPH-1:0] sync1_q;
  logic [NUM_PERIPH-1:0] sync2_q;
  logic [NUM_PERIPH-1:0] dly_q;
  logic [NUM_SRC-1:0]    pending_q,    pending_d;
  logic [NUM_SRC-1:0]    mask_q,       mask_d;
  logic [VEC_WIDTH-1:0]  int_vec_q,    int_vec_d;
  logic [VEC_WIDTH-1:0]  in_service_q, in_service_d;
  state_e                state_q,      state_d;

  logic [NUM_PERIPH-1:0] rise_s;
  logic [NUM_SRC-1:0]    set_s;
  logic [NUM_SRC-1:0]    clr_s;
  logic [NUM_SRC-1:0]    elig_s;

  // Request sources: synchronised peripheral rising edges plus the raw syscall pulse
  always_comb begin
    rise_s = sync2_q & ~dly_q;
    set_s  = {rise_s, bus.syscall_req};
    elig_s = pending_q & ~mask_q;
  end

  // Next-state for arbitration FSM, pending set/clear and mask write
  always_comb begin
    state_d      = state_q;
    int_vec_d    = int_vec_q;
    in_service_d = in_service_q;
    clr_s        = SRC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (|elig_s) begin
          int_vec_d = prio_code(elig_s);
          state_d   = ST_REQ;
        end else begin
          int_vec_d = VEC_NONE;
        end
      end
      ST_REQ: begin
        // int_vec is frozen here: neither mask writes nor new arrivals touch it
        if (bus.int_ack) begin
          clr_s        = code_onehot(int_vec_q);
          in_service_d = int_vec_q;
          int_vec_d    = VEC_NONE;
          state_d      = ST_SERVICE;
        end else begin
          int_vec_d = int_vec_q;
        end
      end
      ST_SERVICE: begin
        int_vec_d = VEC_NONE;
        if (bus.eoi) begin
          in_service_d = VEC_NONE;
          state_d      = ST_IDLE;
        end else begin
          in_service_d = in_service_q;
        end
      end
      default: begin
        int_vec_d    = VEC_NONE;
        in_service_d = VEC_NONE;
        state_d      = ST_IDLE;
      end
    endcase
    // A fresh edge wins over the clear caused by the acknowledge
    pending_d = (pending_q & ~clr_s) | set_s;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  // State, outputs, synchronisers and edge registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= PERIPH_NONE;
      sync2_q      <= PERIPH_NONE;
      dly_q        <= PERIPH_NONE;
      pending_q    <= SRC_NONE;
      mask_q       <= SRC_ALL;
      int_vec_q    <= VEC_NONE;
      in_service_q <= VEC_NONE;
      state_q      <= ST_IDLE;
    end else begin
      sync1_q      <= bus.irq_in;
      sync2_q      <= sync1_q;
      dly_q        <= sync2_q;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_vec_q    <= int_vec_d;
      in_service_q <= in_service_d;
      state_q      <= state_d;
    end
  end

  assign bus.int_vec    = int_vec_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.in_service = in_service_q;

endmodule

// File: doc/mbscore_int_arbiter.md
Name: mbscore_int_arbiter

Overview:
- Upstream stage of the core interrupt controller.
- Collects raw interrupt requests: the core syscall pulse plus six asynchronous peripheral lines (keyboard, mouse, uart, storage, ethernet, cf).
- Latches requests as pending, applies a software mask and picks one by fixed priority.
- Drives a stable encoded int_vec to the interrupt controller, then tracks the in-service interrupt until the core signals end-of-interrupt.

Parameters:
- NUM_SRC, 7, number of interrupt sources; index 0 = syscall, 1..6 = keyboard, mouse, uart, storage, ethernet, cf.
- VEC_WIDTH, 3, width of int_vec; equals INT_SEL_WIDTH. Code for source i is i+1; code 0 means no request.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- syscall_req  in  1  one-cycle syscall pulse from core, synchronous to clk
- irq_in  in  NUM_SRC-1  asynchronous peripheral request levels; bit j maps to source j+1
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NUM_SRC  new mask value; 1 = source masked
- int_ack  in  1  downstream accepted current int_vec (setINTR)
- eoi  in  1  one-cycle end-of-interrupt pulse from core
- int_vec  out  VEC_WIDTH  encoded request to interrupt controller, registered
- pending  out  NUM_SRC  pending flags, registered
- mask  out  NUM_SRC  mask register readback
- in_service  out  VEC_WIDTH  code of interrupt being serviced; 0 = none

Behaviour:
- Reset (asynchronous, rst_n=0):
  - int_vec=0, in_service=0, pending=0.
  - mask all ones (every source masked).
  - Synchronisers and edge registers cleared.
  - State = IDLE.
  - Reset mid-service abandons the request; no pending flag is retained.
- Input path:
  - Each irq_in bit passes through a 2-flop synchroniser and a delay flop.
  - Rising edge of the synchronised level sets the pending bit.
  - A level held high sets pending once only; it must go low and high again to re-request.
  - syscall_req is not synchronised; a high sample sets pending[0] on that edge.
- Latency:
  - irq_in rising and first sampled high at edge k: pending set at edge k+2, int_vec valid after edge k+3.
  - syscall_req high at edge k: pending[0] set at edge k, int_vec valid after edge k+1.
- Mask:
  - Written on the mask_we edge.
  - Masked sources still latch pending but are not selected.
  - Unmasking an already-pending source makes it eligible on the next IDLE cycle.
- Priority: fixed; lowest index wins (syscall highest, cf lowest).
- State machine:
  - IDLE: if any (pending & ~mask) bit is set, int_vec <= code of highest-priority eligible source; go to REQ. Otherwise int_vec holds 0.
  - REQ: int_vec held constant. It is not withdrawn or changed by a mask write or by higher-priority arrivals. On int_ack: clear that source's pending bit, in_service <= int_vec, int_vec <= 0, go to SERVICE.
  - SERVICE: int_vec stays 0 (no nesting). On eoi: in_service <= 0, go to IDLE. The next selection is made in the following IDLE cycle, so there is at least one cycle of int_vec=0 between requests.
- Simultaneous events:
  - New edge on a source in the same cycle its pending bit is cleared by int_ack: pending stays 1 (set wins).
  - mask_we together with IDLE selection: selection uses the old mask.
  - int_ack outside REQ and eoi outside SERVICE are ignored.
  - int_ack and eoi in the same cycle in REQ: the ack is taken, the eoi is ignored.
- Arithmetic: int_vec code = source index + 1, zero-extended to VEC_WIDTH. NUM_SRC must be at most 2^VEC_WIDTH-1.

Test Plan:
- Reset, then mask_we with mask_wdata=7'h00; pulse syscall_req at edge k -> pending=7'h01; int_vec=1 after edge k+1; int_ack -> in_service=1, int_vec=0, pending=0; eoi -> in_service=0.
- Unmasked; irq_in[2] (uart) rising at edge k -> pending[3]=1 at k+2; int_vec=4 after k+3; held unchanged for 10 cycles without int_ack.
- Raise irq_in[5] (cf) and irq_in[0] (keyboard) together -> int_vec=2 first; after ack and eoi, one cycle of int_vec=0, then int_vec=7.
- mask=7'h02 (keyboard masked); keyboard edge -> pending[1]=1, int_vec stays 0; write mask=0 -> int_vec=2 two cycles later.
- In REQ with int_vec=4, second uart edge coincides with int_ack -> pending[3] remains 1; after eoi -> int_vec=4 again.
- Assert rst_n=0 while in SERVICE with in_service=3 -> all outputs return to reset values immediately, and no request follows the release of reset.
